// File: rtl/block_mem_responder_if.sv
// block_mem_responder_if
//   Request/response bundle between the data-cache controller (master) and
//   the main-memory responder (slave).
//
//   rd_req      master -> slave  block read request (level sampled while idle)
//   wr_req      master -> slave  word write request (level sampled while idle)
//   adr         master -> slave  word address
//   wr_data     master -> slave  word to write
//   busy        slave -> master  request in flight
//   mem_ready   slave -> master  one-cycle completion pulse
//   block_data  slave -> master  last fetched 4-word block, word i at [32i+31:32i]
//   rd_cnt      slave -> master  completed reads, modulo 8192
//   wr_cnt      slave -> master  completed writes, modulo 8192
interface block_mem_responder_if #(
  parameter int LEN_ADR  = 15,
  parameter int LEN_DATA = 32
);
  logic                  rd_req;
  logic                  wr_req;
  logic [LEN_ADR-1:0]    adr;
  logic [LEN_DATA-1:0]   wr_data;
  logic                  busy;
  logic                  mem_ready;
  logic [4*LEN_DATA-1:0] block_data;
  logic [12:0]           rd_cnt;
  logic [12:0]           wr_cnt;

  modport master (
    output rd_req, wr_req, adr, wr_data,
    input  busy, mem_ready, block_data, rd_cnt, wr_cnt
  );

  modport slave (
    input  rd_req, wr_req, adr, wr_data,
    output busy, mem_ready, block_data, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/block_mem_responder.sv
// block_mem_responder
//   Main-memory end of the data-cache fill/write handshake. A read returns the
//   aligned 4-word block containing adr after LATENCY cycles; a write stores
//   one word after the same latency. Completed reads and writes are counted.
//
//   clk   in  system clock, all state on the rising edge
//   rst   in  asynchronous active-low reset
//   bus   slave modport of block_mem_responder_if (requests in, busy,
//             mem_ready, block_data and the two counters out)
//
//   Storage is split into four word banks selected by adr[1:0] so a whole
//   block is fetched with one read port per bank in a single cycle.
module block_mem_responder #(
  parameter int LEN_ADR  = 15,
  parameter int LEN_DATA = 32,
  parameter int LATENCY  = 4,
  parameter int DEPTH    = 32768
) (
  input logic                  clk,
  input logic                  rst,
  block_mem_responder_if.slave bus
);

  localparam int         BANK_DEPTH = DEPTH / 4;
  localparam int         BLK_W      = LEN_ADR - 2;
  localparam logic [3:0] LAT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg;
  logic [3:0]          lat_cnt_reg;
  logic                op_write_reg;
  logic [LEN_ADR-1:0]  adr_reg;
  logic [LEN_DATA-1:0] wr_data_reg;
  logic                mem_ready_reg;
  logic                fill_valid_reg;
  logic [12:0]         rd_cnt_reg;
  logic [12:0]         wr_cnt_reg;

  logic                commit;
  logic                commit_rd;
  logic                commit_wr;
  logic [BLK_W-1:0]    blk;
  logic [LEN_DATA-1:0] fill_word [4];

  // The operation is carried out on the last BUSY cycle.
  assign commit    = (state_reg == BUSY) && (lat_cnt_reg == 4'd0);
  assign commit_rd = commit && !op_write_reg;
  assign commit_wr = commit && op_write_reg;
  assign blk       = adr_reg[LEN_ADR-1:2];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= 4'd0;
      op_write_reg   <= 1'b0;
      adr_reg        <= '0;
      wr_data_reg    <= '0;
      mem_ready_reg  <= 1'b0;
      fill_valid_reg <= 1'b0;
      rd_cnt_reg     <= 13'd0;
      wr_cnt_reg     <= 13'd0;
    end else begin
      mem_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A write takes priority; a simultaneous read is dropped.
          if (bus.wr_req) begin
            op_write_reg <= 1'b1;
            adr_reg      <= bus.adr;
            wr_data_reg  <= bus.wr_data;
            lat_cnt_reg  <= LAT_LOAD;
            state_reg    <= BUSY;
          end else if (bus.rd_req) begin
            op_write_reg <= 1'b0;
            adr_reg      <= bus.adr;
            lat_cnt_reg  <= LAT_LOAD;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (lat_cnt_reg == 4'd0) begin
            state_reg     <= RESP;
            mem_ready_reg <= 1'b1;
            if (!op_write_reg) begin
              fill_valid_reg <= 1'b1;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (op_write_reg) begin
            wr_cnt_reg <= wr_cnt_reg + 13'd1;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + 13'd1;
          end
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word banks
  //   Each bank holds (word XOR word_address). With the banks at their
  //   all-zero power-up contents this makes every word read back as its own
  //   address, so no initialisation pass is needed and reset leaves the
  //   contents alone. The XOR is undone on the registered read.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [LEN_DATA-1:0] bank_mem [BANK_DEPTH] = '{default: '0};
      logic [LEN_DATA-1:0] bank_q_reg;
      logic [LEN_DATA-1:0] key;

      assign key = LEN_DATA'({blk, 2'(gi)});

      always_ff @(posedge clk) begin
        if (commit_wr && (adr_reg[1:0] == 2'(gi))) begin
          bank_mem[blk] <= wr_data_reg ^ key;
        end
        if (commit_rd) begin
          bank_q_reg <= bank_mem[blk] ^ key;
        end
      end

      assign fill_word[gi] = bank_q_reg;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy      = (state_reg != IDLE);
  assign bus.mem_ready = mem_ready_reg;
  assign bus.rd_cnt    = rd_cnt_reg;
  assign bus.wr_cnt    = wr_cnt_reg;
  // The bank output registers are not reset; the valid flag masks them to
  // zero until the first fill after reset completes.
  assign bus.block_data = fill_valid_reg
                        ? {fill_word[3], fill_word[2], fill_word[1], fill_word[0]}
                        : '0;

endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder
//   Self-checking bench for block_mem_responder. A plain word array holds the
//   expected memory contents; expected blocks and counters are derived from it.
module tb_block_mem_responder;

  localparam int LATENCY = 4;

  logic clk;
  logic rst;

  block_mem_responder_if #(.LEN_ADR(15), .LEN_DATA(32)) bus ();

  block_mem_responder #(
    .LEN_ADR (15),
    .LEN_DATA(32),
    .LATENCY (LATENCY),
    .DEPTH   (32768)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0]  model_mem [32768];
  int           exp_rd;
  int           exp_wr;
  logic [127:0] exp_block;

  function automatic logic [127:0] exp_blk(input logic [14:0] a);
    int b;
    b = int'(a) & ~3;
    return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
  endfunction

  // Issue one request from an IDLE sample point (#1 after an edge), wait for
  // mem_ready and return the number of edges from acceptance to the pulse
  // (-1 if it never came). Ends at the IDLE sample point after RESP.
  task automatic do_req(input bit rd, input bit wr, input logic [14:0] a,
                        input logic [31:0] d, output int lat);
    bus.rd_req  = rd;
    bus.wr_req  = wr;
    bus.adr     = a;
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    $display("txn rd=%0b wr=%0b adr=%0d data=%h lat=%0d blk=%h rd_cnt=%0d wr_cnt=%0d",
             rd, wr, a, d, lat, bus.block_data, bus.rd_cnt, bus.wr_cnt);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_rd    = 0;
    exp_wr    = 0;
    exp_block = '0;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_req  = 1'b0;
    bus.adr     = '0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.mem_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags busy/ready=%b required 00", {bus.busy, bus.mem_ready});
    end
    n_cmp++;
    if (bus.block_data !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_block got %h required 0", bus.block_data);
    end
    n_cmp++;
    if (bus.rd_cnt !== 13'd0 || bus.wr_cnt !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_cnt rd=%0d wr=%0d required 0/0", bus.rd_cnt, bus.wr_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_rd = 0; exp_wr = 0; exp_block = '0;
  endtask

  task automatic test_read_basic();
    int busy_cnt = 0;
    int rdy_cnt  = 0;
    int rdy_at   = -1;
    bus.rd_req = 1'b1;
    bus.adr    = 15'd1000;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.mem_ready) begin
        rdy_cnt++;
        rdy_at = k;
      end
      @(posedge clk); #1;
    end
    exp_rd++;
    exp_block = exp_blk(15'd1000);
    $display("txn read adr=1000 busy_cycles=%0d ready_at=%0d blk=%h", busy_cnt, rdy_at, bus.block_data);
    n_cmp++;
    if (busy_cnt != LATENCY + 1) begin
      n_fail++;
      $display("FAIL read_busy_cycles got %0d required %0d", busy_cnt, LATENCY + 1);
    end
    n_cmp++;
    if (rdy_cnt != 1 || rdy_at != LATENCY) begin
      n_fail++;
      $display("FAIL read_ready_timing pulses=%0d at=%0d required 1 at %0d", rdy_cnt, rdy_at, LATENCY);
    end
    n_cmp++;
    if (bus.block_data !== {32'd1003, 32'd1002, 32'd1001, 32'd1000}) begin
      n_fail++;
      $display("FAIL read_block got %h required %h", bus.block_data,
               {32'd1003, 32'd1002, 32'd1001, 32'd1000});
    end
    n_cmp++;
    if (bus.rd_cnt !== 13'(exp_rd) || bus.wr_cnt !== 13'(exp_wr)) begin
      n_fail++;
      $display("FAIL read_cnt rd=%0d wr=%0d required %0d/%0d", bus.rd_cnt, bus.wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_write_then_read();
    int lat;
    do_req(1'b0, 1'b1, 15'd1001, 32'hDEADBEEF, lat);
    model_mem[1001] = 32'hDEADBEEF;
    exp_wr++;
    n_cmp++;
    if (lat != LATENCY) begin
      n_fail++;
      $display("FAIL write_latency got %0d required %0d", lat, LATENCY);
    end
    n_cmp++;
    if (bus.block_data !== exp_block) begin
      n_fail++;
      $display("FAIL write_block_hold got %h required %h", bus.block_data, exp_block);
    end
    do_req(1'b1, 1'b0, 15'd1003, 32'h0, lat);
    exp_rd++;
    exp_block = exp_blk(15'd1003);
    n_cmp++;
    if (bus.block_data !== {32'd1003, 32'd1002, 32'hDEADBEEF, 32'd1000}) begin
      n_fail++;
      $display("FAIL wr_rd_block got %h required %h", bus.block_data,
               {32'd1003, 32'd1002, 32'hDEADBEEF, 32'd1000});
    end
    n_cmp++;
    if (bus.rd_cnt !== 13'(exp_rd) || bus.wr_cnt !== 13'(exp_wr)) begin
      n_fail++;
      $display("FAIL wr_rd_cnt rd=%0d wr=%0d required %0d/%0d", bus.rd_cnt, bus.wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    logic [31:0] d;
    d = $urandom;
    do_req(1'b1, 1'b1, 15'd8, d, lat);
    model_mem[8] = d;
    exp_wr++;
    n_cmp++;
    if (lat != LATENCY) begin
      n_fail++;
      $display("FAIL simul_latency got %0d required %0d", lat, LATENCY);
    end
    n_cmp++;
    if (bus.rd_cnt !== 13'(exp_rd) || bus.wr_cnt !== 13'(exp_wr)) begin
      n_fail++;
      $display("FAIL simul_cnt rd=%0d wr=%0d required %0d/%0d", bus.rd_cnt, bus.wr_cnt, exp_rd, exp_wr);
    end
    n_cmp++;
    if (bus.block_data !== exp_block) begin
      n_fail++;
      $display("FAIL simul_block got %h required %h", bus.block_data, exp_block);
    end
    do_req(1'b1, 1'b0, 15'd9, 32'h0, lat);
    exp_rd++;
    exp_block = exp_blk(15'd9);
    n_cmp++;
    if (bus.block_data !== exp_block) begin
      n_fail++;
      $display("FAIL simul_readback got %h required %h", bus.block_data, exp_block);
    end
  endtask

  task automatic test_ignore_busy();
    int rdy_cnt = 0;
    bus.rd_req = 1'b1;
    bus.adr    = 15'd1000;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 2) begin
        bus.rd_req = 1'b1;
        bus.adr    = 15'd2000;
      end
      if (k == 3) bus.rd_req = 1'b0;
      @(posedge clk); #1;
      if (bus.mem_ready) rdy_cnt++;
    end
    exp_rd++;
    exp_block = exp_blk(15'd1000);
    $display("txn read adr=1000 with ignored adr=2000 pulses=%0d blk=%h", rdy_cnt, bus.block_data);
    n_cmp++;
    if (rdy_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_ignore_pulses got %0d required 1", rdy_cnt);
    end
    n_cmp++;
    if (bus.block_data !== exp_block) begin
      n_fail++;
      $display("FAIL busy_ignore_block got %h required %h", bus.block_data, exp_block);
    end
    n_cmp++;
    if (bus.rd_cnt !== 13'(exp_rd) || bus.wr_cnt !== 13'(exp_wr)) begin
      n_fail++;
      $display("FAIL busy_ignore_cnt rd=%0d wr=%0d required %0d/%0d", bus.rd_cnt, bus.wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset_midwrite();
    int lat;
    bus.wr_req  = 1'b1;
    bus.adr     = 15'd5;
    bus.wr_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    $display("txn reset during write adr=5 busy=%b ready=%b blk=%h", bus.busy, bus.mem_ready, bus.block_data);
    n_cmp++;
    if ({bus.busy, bus.mem_ready} !== 2'b00 || bus.block_data !== 128'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs busy/ready=%b blk=%h required 00 and 0",
               {bus.busy, bus.mem_ready}, bus.block_data);
    end
    n_cmp++;
    if (bus.rd_cnt !== 13'd0 || bus.wr_cnt !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_cnt rd=%0d wr=%0d required 0/0", bus.rd_cnt, bus.wr_cnt);
    end
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_rd = 0; exp_wr = 0; exp_block = '0;
    do_req(1'b1, 1'b0, 15'd4, 32'h0, lat);
    exp_rd++;
    exp_block = exp_blk(15'd4);
    n_cmp++;
    if (bus.block_data[63:32] !== 32'd5) begin
      n_fail++;
      $display("FAIL midreset_word1 got %h required 5", bus.block_data[63:32]);
    end
    n_cmp++;
    if (bus.block_data !== exp_block || bus.rd_cnt !== 13'(exp_rd)) begin
      n_fail++;
      $display("FAIL midreset_read blk=%h rd=%0d required %h/%0d", bus.block_data, bus.rd_cnt, exp_block, exp_rd);
    end
  endtask

  task automatic test_random();
    int lat;
    int sel;
    logic [14:0] a;
    logic [31:0] d;
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      d   = $urandom;
      if (sel < 5) begin
        a = 15'($urandom_range(0, 32767));
        do_req(1'b1, 1'b0, a, d, lat);
        exp_rd++;
        exp_block = exp_blk(a);
      end else begin
        a = 15'($urandom_range(0, 16383));
        do_req(sel == 9, 1'b1, a, d, lat);
        model_mem[a] = d;
        exp_wr++;
      end
      n_cmp++;
      if (lat != LATENCY) begin
        n_fail++;
        $display("FAIL rand_latency op=%0d got %0d required %0d", n, lat, LATENCY);
      end
      n_cmp++;
      if (bus.block_data !== exp_block) begin
        n_fail++;
        $display("FAIL rand_block op=%0d got %h required %h", n, bus.block_data, exp_block);
      end
      n_cmp++;
      if (bus.rd_cnt !== 13'(exp_rd % 8192) || bus.wr_cnt !== 13'(exp_wr % 8192)) begin
        n_fail++;
        $display("FAIL rand_cnt op=%0d rd=%0d wr=%0d required %0d/%0d", n, bus.rd_cnt, bus.wr_cnt,
                 exp_rd % 8192, exp_wr % 8192);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [14:0] a;
    apply_reset();
    for (int n = 0; n < 8200; n++) begin
      a = 15'(1000 + n);
      do_req(1'b1, 1'b0, a, 32'h0, lat);
      exp_rd++;
      exp_block = exp_blk(a);
      n_cmp++;
      if (lat != LATENCY || bus.block_data !== exp_block) begin
        n_fail++;
        $display("FAIL wrap_read n=%0d lat=%0d blk=%h required %0d/%h", n, lat, bus.block_data, LATENCY, exp_block);
      end
    end
    n_cmp++;
    if (bus.rd_cnt !== 13'd8) begin
      n_fail++;
      $display("FAIL rd_cnt_wrap got %0d required 8", bus.rd_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      a = 15'(32764 + i);
      do_req(1'b1, 1'b0, a, 32'h0, lat);
      n_cmp++;
      if (bus.block_data !== {32'd32767, 32'd32766, 32'd32765, 32'd32764}) begin
        n_fail++;
        $display("FAIL top_block adr=%0d got %h required %h", a, bus.block_data,
                 {32'd32767, 32'd32766, 32'd32765, 32'd32764});
      end
    end
    a = 15'd3;
    do_req(1'b1, 1'b0, a, 32'h0, lat);
    exp_block = exp_blk(a);
    n_cmp++;
    if (bus.block_data !== exp_block) begin
      n_fail++;
      $display("FAIL bottom_block got %h required %h", bus.block_data, exp_block);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) model_mem[i] = 32'(i);
    exp_rd = 0; exp_wr = 0; exp_block = '0;
    test_reset();
    test_read_basic();
    test_write_then_read();
    test_simultaneous();
    test_ignore_busy();
    test_reset_midwrite();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/block_mem_responder.md
Name: block_mem_responder

Overview:
- Main-memory responder for the direct-mapped data cache: serves cache-line fill requests and single-word write requests.
- A read request returns one aligned 4-word, 128-bit block after a fixed access latency.
- The cache controller is the initiator; this block is the memory end of that handshake.
- It also keeps read and write request counters for hit-rate statistics.

Parameters:
- LEN_ADR, 15, word-address width (matches `LEN_ADR).
- LEN_DATA, 32, word width (matches `LEN_DATA).
- LATENCY, 4, cycles from request acceptance to ready pulse; legal range 1..15.
- DEPTH, 32768, number of words stored (2**LEN_ADR).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_req  in  1  block read request; sampled only in IDLE.
- wr_req  in  1  word write request; sampled only in IDLE.
- adr  in  LEN_ADR  word address; sampled with the accepted request.
- wr_data  in  LEN_DATA  write word; sampled with the accepted write.
- busy  out  1  high while a request is in flight (states BUSY and RESP).
- mem_ready  out  1  one-cycle pulse marking completion of the accepted request.
- block_data  out  4*LEN_DATA  fill block; word i at bits [32i+31:32i].
- rd_cnt  out  13  count of completed reads, wraps modulo 8192.
- wr_cnt  out  13  count of completed writes, wraps modulo 8192.

Behaviour:
- Storage:
  - Array of DEPTH words, initialised at time zero to mem[i] = i (zero-extended to 32 bits).
  - Reset does not clear the array.
- Reset (rst low, asynchronous):
  - state = IDLE; busy = 0, mem_ready = 0, block_data = 0, rd_cnt = 0, wr_cnt = 0.
  - Latency counter = 0; latched request cleared.
  - A request in flight when reset asserts is abandoned: no ready pulse, and no array write if the write had not yet committed.
- FSM states:
  - IDLE: sample inputs. If wr_req, latch adr and wr_data and go to BUSY with op = WRITE. Otherwise, if rd_req, latch blk = adr[LEN_ADR-1:2] and go to BUSY with op = READ.
  - Simultaneous rd_req and wr_req: the write wins and the read is dropped; the initiator must re-issue it.
  - BUSY: the latency counter counts LATENCY-1 down to 0. In the cycle it reaches 0, perform the operation and go to RESP.
    - READ: block_data <= {mem[blk*4+3], mem[blk*4+2], mem[blk*4+1], mem[blk*4]}.
    - WRITE: mem[adr] <= wr_data; block_data unchanged.
  - RESP: mem_ready = 1 for exactly this cycle; increment rd_cnt or wr_cnt; return to IDLE.
- Timing:
  - Request sampled at edge E gives mem_ready high during the cycle after edge E+LATENCY.
  - Back-to-back requests are accepted at the earliest one cycle after RESP (the IDLE cycle).
- busy: 1 in BUSY and RESP, 0 in IDLE; combinational decode of state.
- Handshake:
  - Requests or adr/wr_data changes while busy = 1 are ignored; there is no queueing.
  - Requests are level-sampled. A request held high through RESP is accepted again in the following IDLE, so the initiator must drop it on mem_ready.
- block_data holds the last fill until the next read completes; reads of the same block return identical data.
- Address alignment: adr[1:0] is ignored for reads. The block always starts on a 4-word boundary, including blk = 0 and blk = max (words 32764..32767). There is no wrap past DEPTH.
- Counters wrap from 8191 to 0 without a flag.

Test Plan:
- Reset, then rd_req with adr = 1000 for one cycle -> mem_ready pulses once 4 edges after acceptance; block_data = {1003, 1002, 1001, 1000}; rd_cnt = 1; busy high for 5 cycles.
- wr_req with adr = 1001, wr_data = 0xDEADBEEF, then rd_req adr = 1003 -> after the write's ready pulse, the read returns word1 = 0xDEADBEEF and the other words 1000/1002/1003; wr_cnt = 1, rd_cnt = 1.
- rd_req and wr_req high in the same IDLE cycle with adr = 8 -> only a write occurs; wr_cnt increments, rd_cnt unchanged, block_data unchanged.
- New rd_req with adr = 2000 pulsed while busy -> ignored; the first response is unaffected and no second ready pulse occurs.
- rst low during BUSY of a write to adr = 5 -> all outputs zero immediately; a later read of adr 4 returns word1 = 5.
- Fill-driven loop (request on each ready, adr incrementing from 1000) for 8200 reads -> rd_cnt wraps to 8; addresses 32764..32767 return {32767, 32766, 32765, 32764}.
